// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: request address, response data.
// One request is outstanding at a time; the response carries no tag.
interface fetch_stage_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               ImemReqValid;
    logic [ADDR_W-1:0]  ImemReqAddr;
    logic               ImemReqReady;
    logic               ImemRspValid;
    logic [INSTR_W-1:0] ImemRspData;

    modport master (
        output ImemReqValid,
        output ImemReqAddr,
        input  ImemReqReady,
        input  ImemRspValid,
        input  ImemRspData
    );

    modport slave (
        input  ImemReqValid,
        input  ImemReqAddr,
        output ImemReqReady,
        output ImemRspValid,
        output ImemRspData
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues imem reads, holds the result in IF/ID (1-entry skid).
// Latency: request -> response -> commit, 1 instr / 2 cycles; Stall holds IF/ID, Flush redirects.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned PC halts fetch and sets sticky FetchFault.
module fetch_stage #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [ADDR_W-1:0]  NextPC,
    output logic               PCWriteEn,
    output logic [ADDR_W-1:0]  CurrPC,
    input  logic               Stall,
    input  logic               Flush,
    fetch_stage_if.master      imem,
    output logic               IfIdValid,
    output logic [ADDR_W-1:0]  IfIdPC,
    output logic [INSTR_W-1:0] IfIdInstr,
    output logic               FetchFault
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  curr_pc_q, curr_pc_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic               ifid_vld_q, ifid_vld_d;
    logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic               drop_q, drop_d;
    logic               fault_q, fault_d;
    logic               req_vld;
    logic               commit;
    logic               ifid_free;

    assign ifid_free = !ifid_vld_q || !Stall;

    always_comb begin
        state_d      = state_q;
        curr_pc_d    = curr_pc_q;
        pend_pc_d    = pend_pc_q;
        ifid_vld_d   = ifid_vld_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_d       = skid_q;
        drop_d       = drop_q && !imem.ImemRspValid;
        fault_d      = fault_q;
        req_vld      = 1'b0;
        commit       = 1'b0;

        if (ifid_vld_q && !Stall) begin
            ifid_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (curr_pc_q[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else
`endif
                // A stale response from a flushed request must drain before a new request goes out.
                if (!drop_q) begin
                    req_vld = 1'b1;
                    if (imem.ImemReqReady) begin
                        pend_pc_d = curr_pc_q;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem.ImemRspValid) begin
                    if (ifid_free) begin
                        commit       = 1'b1;
                        ifid_vld_d   = 1'b1;
                        ifid_pc_d    = pend_pc_q;
                        ifid_instr_d = imem.ImemRspData;
                    end else begin
                        skid_d  = imem.ImemRspData;
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (!Stall) begin
                    commit       = 1'b1;
                    ifid_vld_d   = 1'b1;
                    ifid_pc_d    = pend_pc_q;
                    ifid_instr_d = skid_q;
                end
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            curr_pc_d = NextPC;
            state_d   = S_REQ;
        end

        // Flush overrides everything except a halted fetch, which never writes the PC again.
        if (Flush && state_q != S_HALT) begin
            commit       = 1'b1;
            curr_pc_d    = NextPC;
            state_d      = S_REQ;
            ifid_vld_d   = 1'b0;
            ifid_pc_d    = ifid_pc_q;
            ifid_instr_d = ifid_instr_q;
            skid_d       = skid_q;
            fault_d      = fault_q;
            if ((state_q == S_WAIT && !imem.ImemRspValid) ||
                (req_vld && imem.ImemReqReady)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            curr_pc_q    <= RESET_PC;
            pend_pc_q    <= '0;
            ifid_vld_q   <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            skid_q       <= '0;
            drop_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            curr_pc_q    <= curr_pc_d;
            pend_pc_q    <= pend_pc_d;
            ifid_vld_q   <= ifid_vld_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            skid_q       <= skid_d;
            drop_q       <= drop_d;
            fault_q      <= fault_d;
        end
    end

    assign PCWriteEn         = commit;
    assign CurrPC            = curr_pc_q;
    assign imem.ImemReqValid = req_vld;
    assign imem.ImemReqAddr  = curr_pc_q;
    assign IfIdValid         = ifid_vld_q;
    assign IfIdPC            = ifid_pc_q;
    assign IfIdInstr         = ifid_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign FetchFault        = fault_q;
`else
    assign FetchFault        = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; imem responses are driven cycle by cycle.
module tb_fetch_stage;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [63:0] NextPC;
    logic        PCWriteEn;
    logic [63:0] CurrPC;
    logic        Stall, Flush;
    logic        IfIdValid;
    logic [63:0] IfIdPC;
    logic [31:0] IfIdInstr;
    logic        FetchFault;

    fetch_stage_if #(.ADDR_W(64), .INSTR_W(32)) imem_bus ();

    fetch_stage #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .NextPC    (NextPC),
        .PCWriteEn (PCWriteEn),
        .CurrPC    (CurrPC),
        .Stall     (Stall),
        .Flush     (Flush),
        .imem      (imem_bus),
        .IfIdValid (IfIdValid),
        .IfIdPC    (IfIdPC),
        .IfIdInstr (IfIdInstr),
        .FetchFault(FetchFault)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rdy;
        logic        rspv;
        logic [31:0] dat;
        logic        stall;
        logic        flush;
        logic [63:0] npc;
        logic        e_reqv;
        logic [63:0] e_addr;
        logic        e_we;
        logic [63:0] e_cpc;
        logic        e_ifv;
        logic [63:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_step = 0;

    function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] dat,
                                input logic stall, input logic flush, input logic [63:0] npc,
                                input logic e_reqv, input logic [63:0] e_addr, input logic e_we,
                                input logic [63:0] e_cpc, input logic e_ifv, input logic [63:0] e_ifpc,
                                input logic [31:0] e_instr, input logic e_fault);
        vec_t v;
        v.rdy = rdy; v.rspv = rspv; v.dat = dat; v.stall = stall; v.flush = flush; v.npc = npc;
        v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_we = e_we; v.e_cpc = e_cpc;
        v.e_ifv = e_ifv; v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur_step, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rspv, input logic [31:0] dat,
                         input logic stall, input logic flush, input logic [63:0] npc);
        imem_bus.ImemReqReady = rdy;
        imem_bus.ImemRspValid = rspv;
        imem_bus.ImemRspData  = dat;
        Stall  = stall;
        Flush  = flush;
        NextPC = npc;
    endtask

    // Inputs change in the low phase; outputs are sampled 1ns later, well before the rising edge.
    task automatic apply(input vec_t v);
        @(negedge Clk);
        drive(v.rdy, v.rspv, v.dat, v.stall, v.flush, v.npc);
        #1;
        chk("req_valid", {63'b0, imem_bus.ImemReqValid}, {63'b0, v.e_reqv});
        chk("req_addr",  imem_bus.ImemReqAddr, v.e_addr);
        chk("pc_we",     {63'b0, PCWriteEn}, {63'b0, v.e_we});
        chk("curr_pc",   CurrPC, v.e_cpc);
        chk("ifid_vld",  {63'b0, IfIdValid}, {63'b0, v.e_ifv});
        chk("ifid_pc",   IfIdPC, v.e_ifpc);
        chk("ifid_instr", {32'b0, IfIdInstr}, {32'b0, v.e_instr});
        chk("fault",     {63'b0, FetchFault}, {63'b0, v.e_fault});
        cur_step++;
    endtask

    initial begin
        Reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);

        // rdy rspv dat stall flush npc | reqv addr we cpc ifv ifpc instr fault
        vq.push_back(mk(0,0,32'h0,0,0,64'h0,     0,64'h0,  0,64'h0,  0,64'h0,  32'h0,  0));
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     1,64'h0,  0,64'h0,  0,64'h0,  32'h0,  0));
        vq.push_back(mk(0,1,32'hA0,0,0,64'h4,    0,64'h0,  1,64'h0,  0,64'h0,  32'h0,  0));
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     1,64'h4,  0,64'h4,  1,64'h0,  32'hA0, 0));
        vq.push_back(mk(0,1,32'hA1,0,0,64'h8,    0,64'h4,  1,64'h4,  0,64'h0,  32'hA0, 0));
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     1,64'h8,  0,64'h8,  1,64'h4,  32'hA1, 0));
        vq.push_back(mk(0,1,32'hA2,0,0,64'hC,    0,64'h8,  1,64'h8,  0,64'h4,  32'hA1, 0));
        // Stall for 5 cycles with IF/ID valid; next response parks in the skid buffer.
        vq.push_back(mk(1,0,32'h0,1,0,64'h0,     1,64'hC,  0,64'hC,  1,64'h8,  32'hA2, 0));
        vq.push_back(mk(0,1,32'hA3,1,0,64'h10,   0,64'hC,  0,64'hC,  1,64'h8,  32'hA2, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0,0,32'h0,1,0,64'h10, 0,64'hC, 0,64'hC,  1,64'h8,  32'hA2, 0));
        vq.push_back(mk(0,0,32'h0,0,0,64'h10,    0,64'hC,  1,64'hC,  1,64'h8,  32'hA2, 0));
        // Flush in WAIT: stale response must be dropped before fetching from 0x100.
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     1,64'h10, 0,64'h10, 1,64'hC,  32'hA3, 0));
        vq.push_back(mk(0,0,32'h0,0,1,64'h100,   0,64'h10, 1,64'h10, 0,64'hC,  32'hA3, 0));
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     0,64'h100,0,64'h100,0,64'hC,  32'hA3, 0));
        vq.push_back(mk(1,1,32'hDEAD,0,0,64'h0,  0,64'h100,0,64'h100,0,64'hC,  32'hA3, 0));
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     1,64'h100,0,64'h100,0,64'hC,  32'hA3, 0));
        vq.push_back(mk(0,1,32'hB0,0,0,64'h104,  0,64'h100,1,64'h100,0,64'hC,  32'hA3, 0));
        // Flush coincident with a response while stalled.
        vq.push_back(mk(1,0,32'h0,1,0,64'h0,     1,64'h104,0,64'h104,1,64'h100,32'hB0, 0));
        vq.push_back(mk(0,1,32'hB1,1,1,64'h200,  0,64'h104,1,64'h104,1,64'h100,32'hB0, 0));
        // Request held off by ImemReqReady=0 for 4 cycles.
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0,0,32'h0,0,0,64'h0, 1,64'h200,0,64'h200,0,64'h100,32'hB0, 0));
        vq.push_back(mk(1,0,32'h0,0,0,64'h0,     1,64'h200,0,64'h200,0,64'h100,32'hB0, 0));
        vq.push_back(mk(0,1,32'hB2,0,0,64'h204,  0,64'h200,1,64'h200,0,64'h100,32'hB0, 0));
        vq.push_back(mk(0,0,32'h0,0,0,64'h0,     1,64'h204,0,64'h204,1,64'h200,32'hB2, 0));
        vq.push_back(mk(0,0,32'h0,0,0,64'h0,     1,64'h204,0,64'h204,0,64'h200,32'hB2, 0));

        repeat (2) @(negedge Clk);
        #1;
        chk("rst_curr_pc", CurrPC, 64'h0);
        chk("rst_ifid_vld", {63'b0, IfIdValid}, 64'h0);
        chk("rst_ifid_pc", IfIdPC, 64'h0);
        chk("rst_ifid_instr", {32'b0, IfIdInstr}, 64'h0);
        chk("rst_req_vld", {63'b0, imem_bus.ImemReqValid}, 64'h0);
        chk("rst_pc_we", {63'b0, PCWriteEn}, 64'h0);
        chk("rst_fault", {63'b0, FetchFault}, 64'h0);
        @(posedge Clk);
        #2 Reset_n = 1'b1;

        foreach (vq[i]) apply(vq[i]);

        // Fetch lands on PC 0x102 (misaligned).
        apply(mk(1,0,32'h0,0,0,64'h0,   1,64'h204,0,64'h204,0,64'h200,32'hB2,0));
        apply(mk(0,1,32'hC0,0,0,64'h102,0,64'h204,1,64'h204,0,64'h200,32'hB2,0));
`ifdef FETCH_ALIGN_CHECK_EN
        apply(mk(1,0,32'h0,0,0,64'h0,   0,64'h102,0,64'h102,1,64'h204,32'hC0,0));
        for (int i = 0; i < 3; i++)
            apply(mk(1,0,32'h0,0,0,64'h0, 0,64'h102,0,64'h102,0,64'h204,32'hC0,1));
        apply(mk(1,0,32'h0,0,1,64'h300, 0,64'h102,0,64'h102,0,64'h204,32'hC0,1));
`else
        apply(mk(1,0,32'h0,0,0,64'h0,   1,64'h102,0,64'h102,1,64'h204,32'hC0,0));
        apply(mk(0,1,32'hC1,0,0,64'h106,0,64'h102,1,64'h102,0,64'h204,32'hC0,0));
        apply(mk(0,0,32'h0,0,0,64'h0,   1,64'h106,0,64'h106,1,64'h102,32'hC1,0));
`endif

        // Asynchronous reset mid-cycle, then a stray response right after release.
        @(negedge Clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        #2 Reset_n = 1'b0;
        #1;
        chk("mid_rst_curr_pc", CurrPC, 64'h0);
        chk("mid_rst_ifid_vld", {63'b0, IfIdValid}, 64'h0);
        chk("mid_rst_fault", {63'b0, FetchFault}, 64'h0);
        chk("mid_rst_req_vld", {63'b0, imem_bus.ImemReqValid}, 64'h0);
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        apply(mk(0,1,32'hEE,0,0,64'h0, 0,64'h0,0,64'h0,0,64'h0,32'h0,0));
        apply(mk(0,1,32'hEF,0,0,64'h0, 1,64'h0,0,64'h0,0,64'h0,32'h0,0));
        apply(mk(0,0,32'h0,0,0,64'h0,  1,64'h0,0,64'h0,0,64'h0,32'h0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
